// File: rtl/io_port_bank.sv
// io_port_bank: parametrised memory-mapped I/O port bank.
// Each input port passes through a synchroniser and has its own change
// detector, a pending flag and an interrupt mask bit. Output ports are
// registered. The CPU sees a simple read/write bus with one-cycle read latency.
// addr MSB selects the region: 0 = port data, 1 = port control/status.
// DATA_W must be at least 3 so that the control status word fits.
module io_port_bank #(
    parameter int DATA_W      = 8,
    parameter int NUM_PORTS   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = $clog2(NUM_PORTS) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              irq,
    input  logic [DATA_W-1:0] port_in_data  [NUM_PORTS],
    output logic [DATA_W-1:0] port_out_data [NUM_PORTS]
);

    localparam int IDX_W = (ADDR_W > 1) ? ADDR_W - 1 : 1;
    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SYNC_STAGES + 1);

    logic [IDX_W-1:0]     idx;
    logic                 is_ctrl;
    logic                 do_wr;
    logic                 do_rd;
    logic                 in_range;
    logic [NUM_PORTS-1:0] sel;
    logic [NUM_PORTS-1:0] change;
    logic [NUM_PORTS-1:0] clr;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] mask;
    logic [CNT_W-1:0]     settle;
    logic [DATA_W-1:0]    rd_word;

    logic [DATA_W-1:0]    sync_q [NUM_PORTS][SYNC_STAGES];
    logic [DATA_W-1:0]    hist   [NUM_PORTS];
    logic [DATA_W-1:0]    sin    [NUM_PORTS];

    // With a single port there are no index bits; the only port is port 0.
    generate
        if (ADDR_W > 1) begin : g_idx
            assign idx = addr[ADDR_W-2:0];
        end else begin : g_idx_none
            assign idx = '0;
        end
    endgenerate

    assign is_ctrl = addr[ADDR_W-1];

    // A simultaneous write and read performs only the write.
    assign do_wr = wr_en;
    assign do_rd = rd_en & ~wr_en;

    // One-hot port select; in_range stays low for indices beyond NUM_PORTS.
    always_comb begin
        sel      = '0;
        in_range = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel[i]   = 1'b1;
                in_range = 1'b1;
            end
        end
    end

    // Synchronised view of each input port (last synchroniser stage).
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            sin[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Change detection and pending-clear requests for every port.
    always_comb begin
        change = '0;
        clr    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            change[i] = (settle == '0) && (sin[i] != hist[i]);
            clr[i]    = sel[i] & ((do_rd & ~is_ctrl) | (do_wr & is_ctrl & wdata[1]));
        end
    end

    // Read word mux: port data or {nonzero output, pending, mask}; zero when out of range.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (sel[i]) begin
                if (is_ctrl) begin
                    rd_word[0] = mask[i];
                    rd_word[1] = pending[i];
                    rd_word[2] = |port_out_data[i];
                end else begin
                    rd_word = sin[i];
                end
            end
        end
    end

    // Input synchroniser chains and one-cycle history for change detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                    sync_q[i][s] <= '0;
                end
                hist[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                sync_q[i][0] <= port_in_data[i];
                for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                    sync_q[i][s] <= sync_q[i][s-1];
                end
                hist[i] <= sin[i];
            end
        end
    end

    // Settle counter: blocks change detection until the synchronisers and history have filled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            settle <= SETTLE_INIT;
        end else if (settle != '0) begin
            settle <= settle - 1'b1;
        end
    end

    // Output port registers, written through the data region.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                port_out_data[i] <= '0;
            end
        end else if (do_wr && !is_ctrl) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (sel[i]) begin
                    port_out_data[i] <= wdata;
                end
            end
        end
    end

    // Mask and pending flags; a new change event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask    <= '0;
            pending <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (sel[i] && do_wr && is_ctrl) begin
                    mask[i] <= wdata[0];
                end
            end
            pending <= change | (pending & ~clr);
        end
    end

    // Interrupt request registered from the current pending and mask state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pending & mask);
        end
    end

    // Registered read response; rdata holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd) begin
                rdata <= in_range ? rd_word : '0;
            end
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed, table-driven bench for io_port_bank.
// A 16-port instance covers the main register behaviour and interrupt timing;
// a 5-port instance covers out-of-range indices and reset during an access.
module tb_io_port_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // 16-port instance signals
    logic       reset16;
    logic [4:0] addr16;
    logic       wr16;
    logic       rd16;
    logic [7:0] wdata16;
    logic [7:0] rdata16;
    logic       valid16;
    logic       irq16;
    logic [7:0] pin16  [16];
    logic [7:0] pout16 [16];
    logic [7:0] exp16  [16];

    // 5-port instance signals
    logic       reset5;
    logic [3:0] addr5;
    logic       wr5;
    logic       rd5;
    logic [7:0] wdata5;
    logic [7:0] rdata5;
    logic       valid5;
    logic       irq5;
    logic [7:0] pin5  [5];
    logic [7:0] pout5 [5];

    io_port_bank #(.DATA_W(8), .NUM_PORTS(16), .SYNC_STAGES(2)) u_dut16 (
        .clk          (clk),
        .reset        (reset16),
        .addr         (addr16),
        .wr_en        (wr16),
        .rd_en        (rd16),
        .wdata        (wdata16),
        .rdata        (rdata16),
        .rd_valid     (valid16),
        .irq          (irq16),
        .port_in_data (pin16),
        .port_out_data(pout16)
    );

    io_port_bank #(.DATA_W(8), .NUM_PORTS(5), .SYNC_STAGES(2)) u_dut5 (
        .clk          (clk),
        .reset        (reset5),
        .addr         (addr5),
        .wr_en        (wr5),
        .rd_en        (rd5),
        .wdata        (wdata5),
        .rdata        (rdata5),
        .rd_valid     (valid5),
        .irq          (irq5),
        .port_in_data (pin5),
        .port_out_data(pout5)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic        ctrl;
        int unsigned idx;
        logic [7:0]  wdata;
        logic        exp_valid;
        logic [7:0]  exp_rdata;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one access after a negedge; returns at the next negedge with the response visible.
    task automatic acc16(input logic w, input logic r, input logic c, input int unsigned i,
                         input logic [7:0] d);
        wr16    = w;
        rd16    = r;
        addr16  = {c, 4'(i)};
        wdata16 = d;
        @(negedge clk);
        wr16 = 1'b0;
        rd16 = 1'b0;
    endtask

    task automatic acc5(input logic w, input logic r, input logic c, input int unsigned i,
                        input logic [7:0] d);
        wr5    = w;
        rd5    = r;
        addr5  = {c, 3'(i)};
        wdata5 = d;
        @(negedge clk);
        wr5 = 1'b0;
        rd5 = 1'b0;
    endtask

    task automatic chk_pout16(input string tag);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_pout%0d", tag, i), 32'(pout16[i]), 32'(exp16[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset16 = 1'b0; reset5 = 1'b0;
        wr16 = 1'b0; rd16 = 1'b0; addr16 = '0; wdata16 = '0;
        wr5  = 1'b0; rd5  = 1'b0; addr5  = '0; wdata5  = '0;
        for (int i = 0; i < 16; i++) begin
            pin16[i] = 8'h00;
            exp16[i] = 8'h00;
        end
        for (int i = 0; i < 5; i++) pin5[i] = 8'h00;
        pin16[3] = 8'hA5;

        // {wr, rd, ctrl, idx, wdata, exp_valid, exp_rdata}; rdata must hold when exp_valid=0
        vecs[0]  = '{1'b1, 1'b0, 1'b0,  5, 8'h3C, 1'b0, 8'hA5};
        vecs[1]  = '{1'b0, 1'b1, 1'b1,  5, 8'h00, 1'b1, 8'h04};
        vecs[2]  = '{1'b0, 1'b1, 1'b0,  5, 8'h00, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 1'b1,  2, 8'h01, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 1'b1,  2, 8'h00, 1'b1, 8'h01};
        vecs[5]  = '{1'b1, 1'b1, 1'b0,  1, 8'hFF, 1'b0, 8'h01};
        vecs[6]  = '{1'b0, 1'b1, 1'b1,  1, 8'h00, 1'b1, 8'h04};
        vecs[7]  = '{1'b1, 1'b0, 1'b1,  9, 8'h03, 1'b0, 8'h04};
        vecs[8]  = '{1'b0, 1'b1, 1'b1,  9, 8'h00, 1'b1, 8'h01};
        vecs[9]  = '{1'b1, 1'b0, 1'b1,  9, 8'hFC, 1'b0, 8'h01};
        vecs[10] = '{1'b0, 1'b1, 1'b1,  9, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 15, 8'h80, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 15, 8'h00, 1'b1, 8'h04};
        vecs[13] = '{1'b0, 1'b1, 1'b0,  3, 8'h00, 1'b1, 8'hA5};
        vecs[14] = '{1'b1, 1'b1, 1'b1,  4, 8'h01, 1'b0, 8'hA5};
        vecs[15] = '{1'b0, 1'b1, 1'b1,  4, 8'h00, 1'b1, 8'h01};
        vecs[16] = '{1'b1, 1'b0, 1'b1,  4, 8'h00, 1'b0, 8'h01};

        // Reset state of the 16-port instance
        repeat (3) @(negedge clk);
        chk("rst_rdata", 32'(rdata16), 32'h0);
        chk("rst_valid", 32'(valid16), 32'h0);
        chk("rst_irq",   32'(irq16),   32'h0);
        chk_pout16("rst");

        // Release with a nonzero pin: no spurious pending after the settle window
        reset16 = 1'b1;
        repeat (5) @(negedge clk);
        chk("settle_irq", 32'(irq16), 32'h0);
        acc16(1'b0, 1'b1, 1'b1, 3, 8'h00);
        chk("settle_ctrl3_valid", 32'(valid16), 32'h1);
        chk("settle_ctrl3_rdata", 32'(rdata16), 32'h00);
        acc16(1'b0, 1'b1, 1'b0, 3, 8'h00);
        chk("data3_valid", 32'(valid16), 32'h1);
        chk("data3_rdata", 32'(rdata16), 32'hA5);
        @(negedge clk);
        chk("data3_valid_pulse", 32'(valid16), 32'h0);

        // Table-driven register accesses
        for (int k = 0; k < NVEC; k++) begin
            acc16(vecs[k].wr, vecs[k].rd, vecs[k].ctrl, vecs[k].idx, vecs[k].wdata);
            chk($sformatf("vec%0d_valid", k), 32'(valid16), 32'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_rdata", k), 32'(rdata16), 32'(vecs[k].exp_rdata));
            chk($sformatf("vec%0d_irq", k),   32'(irq16),   32'h0);
        end
        exp16[5]  = 8'h3C;
        exp16[1]  = 8'hFF;
        exp16[15] = 8'h80;
        chk_pout16("tbl");

        // Masked port 2 changes: pending after 3 edges, irq one edge later
        pin16[2] = 8'h11;
        repeat (3) @(negedge clk);
        chk("p2_irq_before", 32'(irq16), 32'h0);
        @(negedge clk);
        chk("p2_irq_rise", 32'(irq16), 32'h1);
        acc16(1'b0, 1'b1, 1'b1, 2, 8'h00);
        chk("p2_ctrl_rdata", 32'(rdata16), 32'h03);
        chk("p2_irq_hold",   32'(irq16),   32'h1);
        acc16(1'b0, 1'b1, 1'b0, 2, 8'h00);
        chk("p2_data_valid", 32'(valid16), 32'h1);
        chk("p2_data_rdata", 32'(rdata16), 32'h11);
        chk("p2_irq_lag",    32'(irq16),   32'h1);
        @(negedge clk);
        chk("p2_irq_fall", 32'(irq16), 32'h0);
        acc16(1'b0, 1'b1, 1'b1, 2, 8'h00);
        chk("p2_ctrl_after", 32'(rdata16), 32'h01);

        // Unmasked port 7: pending without irq, W1C, then W1C colliding with a change
        pin16[7] = 8'h5A;
        repeat (4) @(negedge clk);
        chk("p7_irq", 32'(irq16), 32'h0);
        acc16(1'b0, 1'b1, 1'b1, 7, 8'h00);
        chk("p7_pending", 32'(rdata16), 32'h02);
        acc16(1'b1, 1'b0, 1'b1, 7, 8'h02);
        acc16(1'b0, 1'b1, 1'b1, 7, 8'h00);
        chk("p7_w1c", 32'(rdata16), 32'h00);
        pin16[7] = 8'hA5;
        repeat (2) @(negedge clk);
        acc16(1'b1, 1'b0, 1'b1, 7, 8'h02);
        acc16(1'b0, 1'b1, 1'b1, 7, 8'h00);
        chk("p7_set_wins", 32'(rdata16), 32'h02);
        chk("p7_irq_end",  32'(irq16),   32'h0);

        // 5-port instance: out-of-range indices
        pin5[0] = 8'h33;
        reset5  = 1'b1;
        repeat (5) @(negedge clk);
        acc5(1'b1, 1'b0, 1'b0, 6, 8'h77);
        acc5(1'b1, 1'b0, 1'b0, 4, 8'h42);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p5_pout%0d", i), 32'(pout5[i]), (i == 4) ? 32'h42 : 32'h0);
        end
        acc5(1'b0, 1'b1, 1'b0, 0, 8'h00);
        chk("p5_d0_rdata", 32'(rdata5), 32'h33);
        acc5(1'b0, 1'b1, 1'b0, 6, 8'h00);
        chk("p5_d6_valid", 32'(valid5), 32'h1);
        chk("p5_d6_rdata", 32'(rdata5), 32'h00);
        acc5(1'b0, 1'b1, 1'b0, 0, 8'h00);
        acc5(1'b0, 1'b1, 1'b1, 7, 8'h00);
        chk("p5_c7_valid", 32'(valid5), 32'h1);
        chk("p5_c7_rdata", 32'(rdata5), 32'h00);
        acc5(1'b0, 1'b1, 1'b0, 0, 8'h00);
        chk("p5_d0_again", 32'(rdata5), 32'h33);
        chk("p5_irq",      32'(irq5),   32'h0);

        // Reset asserted during a read: state clears at once, no rd_valid pulse
        rd5   = 1'b1;
        addr5 = 4'h0;
        #1 reset5 = 1'b0;
        #1;
        chk("mid_rst_rdata", 32'(rdata5),   32'h0);
        chk("mid_rst_valid", 32'(valid5),   32'h0);
        chk("mid_rst_pout4", 32'(pout5[4]), 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_valid_edge", 32'(valid5), 32'h0);
        rd5 = 1'b0;
        @(negedge clk);
        chk("mid_rst_irq",   32'(irq5),   32'h0);
        chk("mid_rst_rdata2", 32'(rdata5), 32'h0);
        reset5 = 1'b1;
        repeat (5) @(negedge clk);
        acc5(1'b0, 1'b1, 1'b0, 0, 8'h00);
        chk("p5_recover", 32'(rdata5), 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
